ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-port access controller and arbiter in front of the single-port 4096x4 RAM.
- Port A is the instruction-fetch requester; port B is the data/loader requester.
- Accepts one request per cycle using round-robin arbitration, with an optional short lock so a requester can fetch multi-nibble operands back-to-back.
- Drives the RAM strobes from registered state and returns registered read data with a fixed latency.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 4, RAM word width.
- MAX_BURST, 3, maximum consecutive lock-held accepts for one port before the other port must be considered.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- a_req_i  in  1  port A request valid
- a_lock_i  in  1  port A requests to keep ownership for its next access
- a_we_i  in  1  port A write (1) / read (0)
- a_addr_i  in  ADDR_W  port A address
- a_din_i  in  DATA_W  port A write data
- a_gnt_o  out  1  port A request accepted this cycle (combinational)
- a_rvalid_o  out  1  port A read data valid pulse
- a_dout_o  out  DATA_W  port A read data
- b_req_i, b_lock_i, b_we_i, b_addr_i, b_din_i, b_gnt_o, b_rvalid_o, b_dout_o: same as port A, for port B
- ram_ren_o  out  1  RAM read enable
- ram_wen_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_din_o  out  DATA_W  RAM write data
- ram_dout_i  in  DATA_W  RAM read data (combinational from RAM)
- busy_o  out  1  an access is in its RAM cycle

Behaviour:
- Reset (async, rst_i=1):
  - All outputs go to 0 immediately: ram_wen_o=0, ram_ren_o=0, rvalid=0, dout=0, busy_o=0.
  - Any in-flight access is dropped; no write is issued.
  - Last-served pointer is set to B, so A wins the first contention.
  - Burst counter=0; lock owner=none.
- Handshake:
  - A request is accepted at a posedge where x_req_i=1 and x_gnt_o=1.
  - The requester holds req, we, addr and din stable until it sees gnt.
  - gnt is combinational from req, the pointer and the lock state.
  - At most one gnt is high per cycle, and gnt is never high without the matching req.
- Arbitration, one accept per cycle, no idle cycle needed between accesses:
  - Only one port requesting: that port wins.
  - Both requesting, with a lock in force (the previous accept had lock=1, the same port is requesting again, and the burst count is below MAX_BURST): the lock owner wins.
  - Both requesting, no lock in force: the port not served last wins.
  - On accept, the last-served pointer is updated to the winner.
  - Burst counter: incremented if the winner equals the previous owner and that accept had lock=1; otherwise set to 1.
  - When the burst count reaches MAX_BURST, lock is ignored for the next arbitration only.
- Pipeline:
  - Cycle 0 (accept): winner's we, addr, din and port id are latched.
  - Cycle 1 (RAM cycle): busy_o=1; ram_addr_o is the latched addr; ram_wen_o=we; ram_ren_o=!we; ram_din_o is the latched din.
  - A write commits at the posedge ending cycle 1.
  - For a read, ram_dout_i is captured into the owner's dout at the end of cycle 1.
  - Cycle 2: the owner's x_rvalid_o=1 for exactly one cycle.
  - Read latency is 2 cycles from accept; full throughput is one access per cycle.
- Outputs when idle:
  - With no accept, the next cycle has ram_ren_o=0, ram_wen_o=0 and busy_o=0.
  - ram_addr_o and ram_din_o keep their last values.
- Data hold:
  - x_dout_o holds the last read value for that port until the next read completes for the same port.
  - Writes produce no rvalid.
- Ordering:
  - Accesses hit the RAM in accept order.
  - A write to address X followed by a read of X on the next accept returns the new data.
  - Simultaneous A-write and B-read of the same address is resolved by arbitration order.
- Lock boundaries:
  - Lock dropped by the owner, or no request from the owner, releases ownership immediately.
  - lock with we=1 is legal.
- Reset mid-access: if rst_i rises during the RAM cycle, wen drops asynchronously and no rvalid is produced after reset release.

Test Plan:
- Reset, then A reads 0x005 (RAM preloaded with 0x9): a_gnt_o high in cycle 0; ram_ren_o=1, ram_addr_o=0x005 in cycle 1; a_rvalid_o=1, a_dout_o=0x9 in cycle 2.
- A and B both request reads every cycle for 6 cycles, no lock: grants go A,B,A,B,A,B; each rvalid lands on the correct port 2 cycles after its grant.
- B writes 0xC to 0x0FF, then A reads 0x0FF on the next cycle: ram_wen_o=1 followed by ram_ren_o=1 on consecutive cycles; a_dout_o=0xC.
- A holds lock=1 with reads of 0x100..0x104 while B requests continuously: A is granted 3 consecutive times, then B once, then A resumes.
- Read with rst_i asserted during the RAM cycle: all outputs 0 asynchronously; no rvalid after release; first contention after reset grants A.
- Only B requests, while a_req_i=0 and a_lock_i toggles: b_gnt_o=1 every cycle; a_gnt_o is never high.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin two-port front end for a single-port RAM, with a bounded lock so one
// requester can issue back-to-back operand fetches. Read data returns two cycles after accept.
module ram_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_req_i,
    input  logic              a_lock_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_din_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_dout_o,
    input  logic              b_req_i,
    input  logic              b_lock_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_din_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_dout_o,
    output logic              ram_ren_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              busy_o
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic              last_b;
    logic              lock_prev;
    logic              owner_b;
    logic [CNT_W-1:0]  burst_cnt;
    logic              rd_b;

    logic              owner_req;
    logic              lock_hold;
    logic              a_gnt;
    logic              b_gnt;
    logic              accept;
    logic              win_we;
    logic              win_lock;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_din;

    always_comb begin
        owner_req = owner_b ? b_req_i : a_req_i;
        // Lock only counts while the owner keeps asking and the burst is not exhausted.
        lock_hold = lock_prev && owner_req && (burst_cnt < CNT_W'(MAX_BURST));
        if (a_req_i && b_req_i)
            a_gnt = lock_hold ? !owner_b : last_b;
        else
            a_gnt = a_req_i;
        b_gnt    = b_req_i && !a_gnt;
        accept   = a_gnt || b_gnt;
        win_we   = b_gnt ? b_we_i   : a_we_i;
        win_lock = b_gnt ? b_lock_i : a_lock_i;
        win_addr = b_gnt ? b_addr_i : a_addr_i;
        win_din  = b_gnt ? b_din_i  : a_din_i;
    end

    assign a_gnt_o = a_gnt;
    assign b_gnt_o = b_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_b     <= 1'b1;
            lock_prev  <= 1'b0;
            owner_b    <= 1'b0;
            burst_cnt  <= '0;
            rd_b       <= 1'b0;
            busy_o     <= 1'b0;
            ram_ren_o  <= 1'b0;
            ram_wen_o  <= 1'b0;
            ram_addr_o <= '0;
            ram_din_o  <= '0;
            a_rvalid_o <= 1'b0;
            b_rvalid_o <= 1'b0;
            a_dout_o   <= '0;
            b_dout_o   <= '0;
        end else begin
            busy_o    <= accept;
            ram_wen_o <= accept && win_we;
            ram_ren_o <= accept && !win_we;
            if (accept) begin
                ram_addr_o <= win_addr;
                ram_din_o  <= win_din;
                rd_b       <= b_gnt;
                last_b     <= b_gnt;
                owner_b    <= b_gnt;
                lock_prev  <= win_lock;
                if (lock_prev && (owner_b == b_gnt) && (burst_cnt < CNT_W'(MAX_BURST)))
                    burst_cnt <= burst_cnt + CNT_W'(1);
                else
                    burst_cnt <= CNT_W'(1);
            end else begin
                lock_prev <= 1'b0;
            end
            // rd_b still names the RAM-cycle owner here; a same-edge accept updates it after.
            a_rvalid_o <= ram_ren_o && !rd_b;
            b_rvalid_o <= ram_ren_o && rd_b;
            if (ram_ren_o && !rd_b)
                a_dout_o <= ram_dout_i;
            if (ram_ren_o && rd_b)
                b_dout_o <= ram_dout_i;
        end
    end
endmodule
